// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request side, and the slave (the arithmetic unit) drives
// the status and result side.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  ready, busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output ready, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. It processes the operands LSB-first, one bit per
// clock, through a single full adder and a registered carry. Subtraction is
// a + ~b + 1: the block inverts b at load time and presets the carry to 1.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_sub_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             bit_s;
    logic             carry_s;
    logic [WIDTH-1:0] res_s;

    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    // Full-adder sum/carry on the current LSBs.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    assign bit_s   = fa_sum(opa_r[0], opb_r[0], carry_r);
    assign carry_s = fa_carry(opa_r[0], opb_r[0], carry_r);

    // Result register with the new sum bit entering at the MSB; on the last
    // step this value is the completed result.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_s = bit_s;
        end else begin : g_res_wn
            assign res_s = {bit_s, res_r[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and datapath strobes; start is only honoured when the block can accept.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(WIDTH - 1)) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, running carry, partial result and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r   <= '0;
            opb_r   <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            opa_r   <= bus.a;
            opb_r   <= bus.mode ? ~bus.b : bus.b;
            carry_r <= bus.mode;
            cnt_r   <= '0;
        end else if (step_s) begin
            opa_r   <= opa_r >> 1;
            opb_r   <= opb_r >> 1;
            res_r   <= res_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    // Result outputs load only on the final step. carry_r there is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            sum_r  <= res_s;
            cout_r <= carry_s;
            ovf_r  <= carry_r ^ carry_s;
        end
    end

    // Handshake status flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s != RUN);
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    assign bus.ready    = ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;

endmodule
